// File: rtl/ram_sync_param.sv
`default_nettype none
// ============================================================================
// ram_sync_param : parametrised single-port RAM, registered read, zero-fill
// Revision       : 1.0
// ============================================================================
module ram_sync_param #(
   parameter int                  DATA_WIDTH = 4,
   parameter int                  ADDR_WIDTH = 4,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  WR,
   input  logic                  RD,
   input  logic [ADDR_WIDTH-1:0] Address,
   input  logic [DATA_WIDTH-1:0] Data,
   input  logic                  Clear,
   output logic [DATA_WIDTH-1:0] Output,
   output logic                  Valid,
   output logic                  Busy,
   output logic                  Dropped
);

   localparam int                  DEPTH       = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   fill_ptr_q, fill_ptr_d;
   logic [DATA_WIDTH-1:0]   out_q, out_d;
   logic                    valid_q, valid_d;
   logic                    dropped_q, dropped_d;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic                    w_accept;
   logic                    w_mem_we;
   logic [ADDR_WIDTH-1:0]   w_mem_addr;
   logic [DATA_WIDTH-1:0]   w_mem_wdata;

   // A Clear edge in IDLE belongs to the sequencer, so user access is refused.
   assign w_accept = (state_q == ST_IDLE) && !Clear;

   always_comb begin
      state_d     = state_q;
      fill_ptr_d  = fill_ptr_q;
      out_d       = out_q;
      valid_d     = 1'b0;
      dropped_d   = (WR || RD) && !w_accept;
      w_mem_we    = 1'b0;
      w_mem_addr  = Address;
      w_mem_wdata = Data;
      case (state_q)
         ST_FILL: begin
            w_mem_we    = 1'b1;
            w_mem_addr  = fill_ptr_q;
            w_mem_wdata = INIT_VALUE;
            fill_ptr_d  = fill_ptr_q + 1'b1;
            if (fill_ptr_q == c_LAST_ADDR) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            if (Clear) begin
               state_d    = ST_FILL;
               fill_ptr_d = '0;
            end else begin
               w_mem_we = WR;
               if (RD) begin
                  out_d   = mem_q[Address];
                  valid_d = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= ST_FILL;
         fill_ptr_q <= '0;
         out_q      <= '0;
         valid_q    <= 1'b0;
         dropped_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fill_ptr_q <= fill_ptr_d;
         out_q      <= out_d;
         valid_q    <= valid_d;
         dropped_q  <= dropped_d;
      end
   end

   // Array has no reset; read-before-write falls out of the registered read.
   always_ff @(posedge Clk) begin
      if (!Reset && w_mem_we) begin
         mem_q[w_mem_addr] <= w_mem_wdata;
      end
   end

   assign Output  = out_q;
   assign Valid   = valid_q;
   assign Busy    = (state_q == ST_FILL) || Reset;
   assign Dropped = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_sync_param.sv
`default_nettype none
// ============================================================================
// tb_ram_sync_param : directed self-checking bench for ram_sync_param
// Revision          : 1.0
// ============================================================================
module tb_ram_sync_param;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // default 16x4 instance
   logic       rst = 1'b1, wr = 1'b0, rd = 1'b0, clr = 1'b0;
   logic [3:0] addr = '0, din = '0;
   logic [3:0] dout;
   logic       valid, busy, dropped;

   // 32x8 instance
   logic       rst8 = 1'b1, wr8 = 1'b0, rd8 = 1'b0, clr8 = 1'b0;
   logic [4:0] addr8 = '0;
   logic [7:0] din8 = '0;
   logic [7:0] dout8;
   logic       valid8, busy8, dropped8;

   int checks = 0;
   int errors = 0;

   ram_sync_param dut (
      .Clk(clk), .Reset(rst), .WR(wr), .RD(rd), .Address(addr), .Data(din),
      .Clear(clr), .Output(dout), .Valid(valid), .Busy(busy), .Dropped(dropped)
   );

   ram_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .INIT_VALUE(8'hA5)) dut8 (
      .Clk(clk), .Reset(rst8), .WR(wr8), .RD(rd8), .Address(addr8), .Data(din8),
      .Clear(clr8), .Output(dout8), .Valid(valid8), .Busy(busy8), .Dropped(dropped8)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if (busy !== 1'b1 || valid !== 1'b0 || dout !== 4'h0 || dropped !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: busy=%b valid=%b out=%h dropped=%b, want 1 0 0 0",
                  busy, valid, dout, dropped);
      end
      rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         step();
         checks++;
         if (busy !== (k < 16)) begin
            errors++;
            $display("FAIL fill_busy edge %0d: busy=%b want %b", k, busy, k < 16);
         end
      end
   endtask

   task automatic test_read_zero();
      for (int i = 0; i < 16; i++) begin
         rd = 1'b1; addr = 4'(i);
         step();
         checks++;
         if (valid !== 1'b1 || dout !== 4'h0) begin
            errors++;
            $display("FAIL read_zero a=%0d: valid=%b out=%h want 1 0", i, valid, dout);
         end
      end
      rd = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) begin
         wr = 1'b1; addr = 4'(i); din = 4'(i);
         step();
      end
      wr = 1'b0;
      for (int i = 0; i < 16; i++) begin
         rd = 1'b1; addr = 4'(i);
         step();
         checks++;
         if (valid !== 1'b1 || dout !== 4'(i)) begin
            errors++;
            $display("FAIL b2b_read a=%0d: valid=%b out=%h want 1 %h", i, valid, dout, 4'(i));
         end
      end
      rd = 1'b0;
      step();
      checks++;
      if (valid !== 1'b0 || dout !== 4'hF) begin
         errors++;
         $display("FAIL read_hold: valid=%b out=%h want 0 f", valid, dout);
      end
   endtask

   task automatic test_rbw();
      wr = 1'b1; addr = 4'd5; din = 4'b1010;
      step();
      rd = 1'b1; wr = 1'b1; din = 4'b0101;
      step();
      checks++;
      if (valid !== 1'b1 || dout !== 4'b1010) begin
         errors++;
         $display("FAIL rbw_old: valid=%b out=%b want 1 1010", valid, dout);
      end
      wr = 1'b0;
      step();
      checks++;
      if (valid !== 1'b1 || dout !== 4'b0101) begin
         errors++;
         $display("FAIL rbw_new: valid=%b out=%b want 1 0101", valid, dout);
      end
      rd = 1'b0;
      step();
   endtask

   task automatic test_clear();
      clr = 1'b1; wr = 1'b1; addr = 4'd3; din = 4'hC;
      for (int k = 1; k <= 17; k++) begin
         step();
         clr = 1'b0;
         checks++;
         if (busy !== (k <= 16) || dropped !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_fill edge %0d: busy=%b dropped=%b valid=%b want %b 1 0",
                     k, busy, dropped, valid, k <= 16);
         end
      end
      wr = 1'b0;
      step();
      checks++;
      if (dropped !== 1'b0) begin
         errors++;
         $display("FAIL dropped_clear: dropped=%b want 0", dropped);
      end
      for (int i = 0; i < 16; i++) begin
         rd = 1'b1; addr = 4'(i);
         step();
         checks++;
         if (valid !== 1'b1 || dout !== 4'h0) begin
            errors++;
            $display("FAIL clear_read a=%0d: valid=%b out=%h want 1 0", i, valid, dout);
         end
      end
      rd = 1'b0;
   endtask

   task automatic test_reset_mid_fill();
      wr = 1'b1; addr = 4'd2; din = 4'b1001;
      step();
      wr = 1'b0; rd = 1'b1;
      step();
      checks++;
      if (valid !== 1'b1 || dout !== 4'b1001) begin
         errors++;
         $display("FAIL pre_reset_read: valid=%b out=%b want 1 1001", valid, dout);
      end
      rst = 1'b1;
      step();
      rd = 1'b0;
      checks++;
      if (valid !== 1'b0 || dout !== 4'h0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_flight: valid=%b out=%h busy=%b want 0 0 1", valid, dout, busy);
      end
      rst = 1'b0;
      for (int k = 0; k < 7; k++) step();
      rst = 1'b1;
      step();
      checks++;
      if (valid !== 1'b0 || dout !== 4'h0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_fill: valid=%b out=%h busy=%b want 0 0 1", valid, dout, busy);
      end
      rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         step();
         checks++;
         if (busy !== (k < 16)) begin
            errors++;
            $display("FAIL refill_busy edge %0d: busy=%b want %b", k, busy, k < 16);
         end
      end
      rd = 1'b1; addr = 4'd2;
      step();
      rd = 1'b0;
      checks++;
      if (valid !== 1'b1 || dout !== 4'h0) begin
         errors++;
         $display("FAIL refill_read: valid=%b out=%h want 1 0", valid, dout);
      end
   endtask

   task automatic test_wide();
      rst8 = 1'b1;
      step();
      rst8 = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         step();
         if (k >= 31) begin
            checks++;
            if (busy8 !== (k < 32)) begin
               errors++;
               $display("FAIL wide_busy edge %0d: busy=%b want %b", k, busy8, k < 32);
            end
         end
      end
      for (int i = 0; i < 32; i++) begin
         rd8 = 1'b1; addr8 = 5'(i);
         step();
         checks++;
         if (valid8 !== 1'b1 || dout8 !== 8'hA5) begin
            errors++;
            $display("FAIL wide_read a=%0d: valid=%b out=%h want 1 a5", i, valid8, dout8);
         end
      end
      rd8 = 1'b0; wr8 = 1'b1; addr8 = 5'd31; din8 = 8'hFF;
      step();
      wr8 = 1'b0; rd8 = 1'b1;
      step();
      rd8 = 1'b0;
      checks++;
      if (valid8 !== 1'b1 || dout8 !== 8'hFF) begin
         errors++;
         $display("FAIL wide_write31: valid=%b out=%h want 1 ff", valid8, dout8);
      end
   endtask

   initial begin
      test_reset();
      test_read_zero();
      test_back_to_back();
      test_rbw();
      test_clear();
      test_reset_mid_fill();
      test_wide();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ram_sync_param.md
Name: ram_sync_param

Overview:
Parametrised synchronous single-port RAM; the next generation of the team's 16x4 memory block, generalised in data width and depth. Adds a registered read path with a Valid strobe, a hardware zero-fill sequencer run after reset and on demand, and a Busy/Dropped handshake for requests that arrive while the sequencer owns the array. Intended as the general scratch memory for register files and small buffers across the design.

Parameters:
DATA_WIDTH, 4, bits per word.
ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH words, so the default is 16x4.
INIT_VALUE, 0, DATA_WIDTH-bit word written to every location by the fill sequencer.

Ports:
Clk  input  1  single clock, all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
WR  input  1  write request for the current cycle.
RD  input  1  read request for the current cycle.
Address  input  ADDR_WIDTH  word address shared by read and write.
Data  input  DATA_WIDTH  write data.
Clear  input  1  request a full fill of the array with INIT_VALUE (level-sampled).
Output  output  DATA_WIDTH  registered read data.
Valid  output  1  Output was loaded by a read accepted in the previous cycle.
Busy  output  1  fill sequencer active; WR and RD are not accepted.
Dropped  output  1  one-cycle pulse: a WR or RD request arrived while Busy.

Behaviour:
- FSM states: FILL, IDLE. fill_ptr is an ADDR_WIDTH-bit counter.
- Reset high at an edge: state=FILL, fill_ptr=0, Output=0, Valid=0, Dropped=0. Busy=1 while Reset is held. Array contents are not touched by Reset itself.
- FILL, each edge with Reset low: mem[fill_ptr]=INIT_VALUE and fill_ptr increments. On the edge that writes DEPTH-1: state goes to IDLE and fill_ptr wraps to 0.
- Fill timing: Busy is combinational from the state (Busy = state==FILL) and is 0 exactly DEPTH rising edges after the first edge with Reset low.
- IDLE with Clear=1 at an edge: go to FILL with fill_ptr=0. That edge performs no user access, and WR/RD on that edge are dropped. Clear is ignored while already in FILL; the fill does not restart.
- Write, IDLE: WR=1 at an edge writes mem[Address]=Data. Full-width write, no byte enables.
- Read, IDLE: RD=1 at an edge loads Output=mem[Address] and sets Valid=1. Latency is one clock. With RD=0, Valid=0 and Output holds its last value.
- RD and WR together at the same address: read-before-write. Output gets the old word and the array gets Data. Both count as accepted.
- Requests during Busy (FILL state, or the Clear edge): not performed. Valid=0 on the next cycle. Dropped=1 for one cycle after each edge where (WR|RD) was high and the request was not accepted, otherwise 0.
- Reset mid-fill, or mid-access: the sequence restarts from address 0. Any read in flight gets Valid=0.
- Address is always in range (full power-of-two depth), so no bounds checks are needed.
- Width rules: fill_ptr and Address are exactly ADDR_WIDTH bits. No truncation or extension happens on the data path.

Test Plan:
- Reset for 2 cycles, then release, default params: Busy=1 for 16 edges then 0. Reads of addresses 0..15 each return 4'b0000 with Valid one cycle after RD.
- Write Data=Address to addresses 0..15 (WR=1, one per cycle), then read 0..15 back-to-back: Output sequence is 0..15, lagging by one cycle, with Valid continuously 1.
- Write 4'b1010 to address 5, then RD=1, WR=1, Address=5, Data=4'b0101 in one cycle: Output=4'b1010. A following read of address 5 returns 4'b0101.
- Fill the array with nonzero data, pulse Clear for 1 cycle and hold WR=1 on address 3 during the following fill: Busy=1 for 16 cycles and Dropped pulses every cycle. Afterwards every address, including 3, reads 0.
- Assert Reset at fill_ptr=7, hold 1 cycle: Busy stays 1 and the fill restarts at 0, ending exactly 16 edges after release. Output=0 and Valid=0 during Reset.
- DATA_WIDTH=8, ADDR_WIDTH=5, INIT_VALUE=8'hA5: Busy lasts 32 cycles and all 32 addresses read 8'hA5. Then write 8'hFF to address 31 and read it back as 8'hFF.
